reg_file_mp: RTL and testbench

- Multi-ported, parametrised integer register file for the five-stage pipeline, successor to the single-write/dual-read file.
- Provides NUM_RD combinational read ports and NUM_WR synchronous write ports.
- Adds a per-register pending-write scoreboard so decode can detect RAW hazards.
- Register 0 is hardwired to zero and is never marked pending.

---
 rtl/reg_file_mp.sv | 97 +++++++++
 tb/tb_reg_file_mp.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-ported integer register file with a per-register pending-write scoreboard.
// Optional write-first forwarding to the read ports is enabled by REGFILE_BYPASS_EN.
module reg_file_mp #(
  parameter int ADDR_LEN      = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int REG_FILE_SIZE = 32,
  parameter int NUM_RD        = 2,
  parameter int NUM_WR        = 1
) (
  input  logic                         clk,
  input  logic                         nReset,
  input  logic [NUM_RD*ADDR_LEN-1:0]   rs,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*ADDR_LEN-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  input  logic                         issue_en,
  input  logic [ADDR_LEN-1:0]          issue_addr,
  output logic                         any_busy
);

  logic [DATA_WIDTH-1:0]    mem_q [REG_FILE_SIZE];
  logic [DATA_WIDTH-1:0]    mem_d [REG_FILE_SIZE];
  logic [REG_FILE_SIZE-1:0] busy_q;
  logic [REG_FILE_SIZE-1:0] busy_d;

  // Next-state of registers and scoreboard; later ports override earlier ones, issue overrides clear.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    for (int r = 1; r < REG_FILE_SIZE; r++) begin
      for (int j = 0; j < NUM_WR; j++) begin
        mem_d[r]  = (wr_en[j] && (wr_addr[j*ADDR_LEN +: ADDR_LEN] == ADDR_LEN'(r)))
                    ? wr_data[j*DATA_WIDTH +: DATA_WIDTH] : mem_d[r];
        busy_d[r] = (wr_en[j] && (wr_addr[j*ADDR_LEN +: ADDR_LEN] == ADDR_LEN'(r)))
                    ? 1'b0 : busy_d[r];
      end
      busy_d[r] = (issue_en && (issue_addr == ADDR_LEN'(r))) ? 1'b1 : busy_d[r];
    end
    mem_d[0]  = '0;
    busy_d[0] = 1'b0;
  end

  // Register array and scoreboard state.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      for (int r = 0; r < REG_FILE_SIZE; r++) begin
        mem_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_LEN-1:0]   ra_s;
    logic [DATA_WIDTH-1:0] data_s;
    logic                  busy_s;

    assign ra_s = rs[i*ADDR_LEN +: ADDR_LEN];

    // Read mux over valid registers; r0 and out-of-range addresses fall through to zero.
    always_comb begin
      data_s = '0;
      busy_s = 1'b0;
      for (int r = 1; r < REG_FILE_SIZE; r++) begin
        data_s = (ra_s == ADDR_LEN'(r)) ? mem_q[r]  : data_s;
        busy_s = (ra_s == ADDR_LEN'(r)) ? busy_q[r] : busy_s;
      end
`ifdef REGFILE_BYPASS_EN
      for (int r = 1; r < REG_FILE_SIZE; r++) begin
        for (int j = 0; j < NUM_WR; j++) begin
          data_s = ((ra_s == ADDR_LEN'(r)) && wr_en[j] &&
                    (wr_addr[j*ADDR_LEN +: ADDR_LEN] == ADDR_LEN'(r)))
                   ? wr_data[j*DATA_WIDTH +: DATA_WIDTH] : data_s;
          busy_s = ((ra_s == ADDR_LEN'(r)) && wr_en[j] &&
                    (wr_addr[j*ADDR_LEN +: ADDR_LEN] == ADDR_LEN'(r)))
                   ? 1'b0 : busy_s;
        end
      end
`else
      data_s = data_s;
`endif
      data_s = nReset ? data_s : '0;
      busy_s = nReset ? busy_s : 1'b0;
    end

    assign rd[i*DATA_WIDTH +: DATA_WIDTH] = data_s;
    assign rd_busy[i]                     = busy_s;
  end

  assign any_busy = |rd_busy;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed-vector bench for reg_file_mp (2 read ports, 2 write ports, 24 registers).
module tb_reg_file_mp;

  logic        clk;
  logic        nReset;
  logic [4:0]  rs0, rs1;
  logic [9:0]  rs;
  logic [63:0] rd;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [4:0]  wa0, wa1;
  logic [9:0]  wr_addr;
  logic [31:0] wd0, wd1;
  logic [63:0] wr_data;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic        any_busy;
  int          vecs;
  int          errs;

  assign rs      = {rs1, rs0};
  assign wr_addr = {wa1, wa0};
  assign wr_data = {wd1, wd0};

  reg_file_mp #(
    .ADDR_LEN(5), .DATA_WIDTH(32), .REG_FILE_SIZE(24), .NUM_RD(2), .NUM_WR(2)
  ) dut (
    .clk(clk), .nReset(nReset), .rs(rs), .rd(rd), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr), .any_busy(any_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en    = 2'b00;
    wa0      = 5'd0;
    wa1      = 5'd0;
    wd0      = 32'd0;
    wd1      = 32'd0;
    issue_en = 1'b0;
    issue_addr = 5'd0;
  endtask

  task automatic chk_rd(input string name, input int port, input logic [31:0] exp);
    logic [31:0] got;
    got = (port == 0) ? rd[31:0] : rd[63:32];
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: rd%0d got %h expected %h", name, port, got, exp);
    end
  endtask

  task automatic chk_busy(input string name, input logic [1:0] exp_b, input logic exp_any);
    vecs++;
    if (rd_busy !== exp_b || any_busy !== exp_any) begin
      errs++;
      $display("FAIL %s: rd_busy/any_busy got %b/%b expected %b/%b",
               name, rd_busy, any_busy, exp_b, exp_any);
    end
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    idle();
    rs0 = 5'd5;
    rs1 = 5'd0;
    #12;
    chk_rd("reset_init", 0, 32'd0);
    chk_busy("reset_init_busy", 2'b00, 1'b0);
    nReset = 1'b1;
    @(negedge clk);
    wr_en = 2'b01; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
    issue_en = 1'b1; issue_addr = 5'd5;
    cyc();
    idle();
    #1;
    chk_rd("pre_reset_r5", 0, 32'hDEADBEEF);
    chk_busy("pre_reset_busy", 2'b01, 1'b1);
    #2;
    nReset = 1'b0;
    #1;
    chk_rd("in_reset_rd0", 0, 32'd0);
    chk_busy("in_reset_busy", 2'b00, 1'b0);
    @(negedge clk);
    nReset = 1'b1;
    #1;
    chk_rd("post_reset_rd0", 0, 32'd0);
    chk_rd("post_reset_rd1", 1, 32'd0);
    chk_busy("post_reset_busy", 2'b00, 1'b0);
  endtask

  task automatic test_x0();
    @(negedge clk);
    wr_en = 2'b01; wa0 = 5'd0; wd0 = 32'h12345678;
    issue_en = 1'b1; issue_addr = 5'd0;
    rs0 = 5'd0; rs1 = 5'd0;
    cyc();
    idle();
    #1;
    chk_rd("x0_rd0", 0, 32'd0);
    chk_rd("x0_rd1", 1, 32'd0);
    chk_busy("x0_busy", 2'b00, 1'b0);
  endtask

  task automatic test_priority();
    @(negedge clk);
    wr_en = 2'b11; wa0 = 5'd7; wd0 = 32'h11; wa1 = 5'd7; wd1 = 32'h22;
    cyc();
    wr_en = 2'b11; wa0 = 5'd8; wd0 = 32'h33; wa1 = 5'd10; wd1 = 32'h44;
    cyc();
    idle();
    rs0 = 5'd7; rs1 = 5'd8;
    #1;
    chk_rd("prio_r7", 0, 32'h22);
    chk_rd("dual_r8", 1, 32'h33);
    rs1 = 5'd10;
    #1;
    chk_rd("dual_r10", 1, 32'h44);
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    issue_en = 1'b1; issue_addr = 5'd3;
    cyc();
    idle();
    rs0 = 5'd3; rs1 = 5'd7;
    #1;
    chk_busy("sb_issued", 2'b01, 1'b1);
    rs1 = 5'd3;
    #1;
    chk_busy("sb_both_ports", 2'b11, 1'b1);
    rs1 = 5'd7;
    wr_en = 2'b10; wa1 = 5'd3; wd1 = 32'hA5;
    cyc();
    idle();
    #1;
    chk_rd("sb_written", 0, 32'hA5);
    chk_busy("sb_cleared", 2'b00, 1'b0);
  endtask

  task automatic test_collision();
    @(negedge clk);
    issue_en = 1'b1; issue_addr = 5'd9;
    wr_en = 2'b01; wa0 = 5'd9; wd0 = 32'h55;
    cyc();
    idle();
    rs0 = 5'd9; rs1 = 5'd0;
    #1;
    chk_rd("coll_data", 0, 32'h55);
    chk_busy("coll_busy", 2'b01, 1'b1);
    issue_en = 1'b1; issue_addr = 5'd9;
    cyc();
    idle();
    #1;
    chk_busy("reissue_busy", 2'b01, 1'b1);
    wr_en = 2'b01; wa0 = 5'd9; wd0 = 32'h56;
    cyc();
    idle();
    #1;
    chk_busy("reissue_clear", 2'b00, 1'b0);
  endtask

  task automatic test_bypass();
    @(negedge clk);
    wr_en = 2'b01; wa0 = 5'd4; wd0 = 32'h1;
    issue_en = 1'b1; issue_addr = 5'd4;
    cyc();
    idle();
    rs0 = 5'd4; rs1 = 5'd4;
    wr_en = 2'b10; wa1 = 5'd4; wd1 = 32'h2;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk_rd("bypass_rd0", 0, 32'h2);
    chk_rd("bypass_rd1", 1, 32'h2);
    chk_busy("bypass_busy", 2'b00, 1'b0);
`else
    chk_rd("readold_rd0", 0, 32'h1);
    chk_rd("readold_rd1", 1, 32'h1);
    chk_busy("readold_busy", 2'b11, 1'b1);
`endif
    cyc();
    idle();
    #1;
    chk_rd("bypass_after", 0, 32'h2);
    chk_busy("bypass_after_busy", 2'b00, 1'b0);
  endtask

  task automatic test_range();
    @(negedge clk);
    wr_en = 2'b11; wa0 = 5'd23; wd0 = 32'h77; wa1 = 5'd24; wd1 = 32'h88;
    issue_en = 1'b1; issue_addr = 5'd24;
    cyc();
    idle();
    rs0 = 5'd23; rs1 = 5'd24;
    #1;
    chk_rd("range_r23", 0, 32'h77);
    chk_rd("range_r24", 1, 32'd0);
    chk_busy("range_busy", 2'b00, 1'b0);
    issue_en = 1'b1; issue_addr = 5'd23;
    rs1 = 5'd31;
    cyc();
    idle();
    #1;
    chk_rd("range_r31", 1, 32'd0);
    chk_busy("range_r23_busy", 2'b01, 1'b1);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      wr_en = 2'b01; wa0 = 5'(k + 10); wd0 = 32'hC0DE_0000 + 32'(k);
      cyc();
    end
    idle();
    rs0 = 5'd11; rs1 = 5'd14;
    #1;
    chk_rd("b2b_r11", 0, 32'hC0DE_0001);
    chk_rd("b2b_r14", 1, 32'hC0DE_0004);
    rs0 = 5'd12; rs1 = 5'd13;
    #1;
    chk_rd("b2b_r12", 0, 32'hC0DE_0002);
    chk_rd("b2b_r13", 1, 32'hC0DE_0003);
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_x0();
    test_priority();
    test_scoreboard();
    test_collision();
    test_bypass();
    test_range();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
